llr_block_deint: RTL and testbench
==================================

Name: llr_block_deint

Overview:
- Receive-side soft-bit block deinterleaver. Sits directly downstream of the RX PHY soft-bit serializer and consumes its 5-bit LLR stream (valid-only, no backpressure).
- Writes LLRs row-major into a ping-pong pair of banks and reads each full bank column-major.
- Output is an AXI-stream with tlast per block, feeding the FEC decoder.

Parameters:
- pLLR_W, 5, LLR width (signed two's complement).
- pROWS, 32, interleaver rows.
- pCOLS, 64, interleaver columns. Block size N = pROWS*pCOLS. Both must be powers of two.

Ports:
- clk  in  1  single clock (clk_h domain of the serializer).
- rst  in  1  synchronous, active-high reset.
- ival  in  1  input LLR valid.
- ibit  in  pLLR_W  input LLR, signed.
- isof  in  1  start of frame; qualified by ival; the sample carrying isof is written at index 0.
- m_ax_tdata  out  pLLR_W  deinterleaved LLR.
- m_ax_tvalid  out  1  output valid.
- m_ax_tready  in  1  downstream ready.
- m_ax_tlast  out  1  last LLR of a block.
- ovf  out  1  sticky overflow flag; cleared only by rst.
- obank_full  out  2  per-bank "full / awaiting read" status.

Behaviour:
- Reset: tvalid=0, tlast=0, tdata=0, ovf=0, obank_full=0, write bank=0, both write/read counters=0, write FSM=WR, read FSM=IDLE.
- Write FSM states: WR, DROP.
- WR:
  - Each ival writes ibit at linear address wcnt (0..N-1) in bank wb, then wcnt increments.
  - The write at wcnt=N-1 sets obank_full[wb], toggles wb and clears wcnt.
  - If the new wb is still full at that moment, go to DROP and set ovf.
- DROP:
  - ival samples are discarded.
  - When obank_full[wb] clears, return to WR with wcnt=0.
  - An isof arriving in DROP is also discarded; the block resumes only once the bank frees.
- isof in WR with wcnt!=0: abandon the partial fill, write the isof sample at address 0 of the same bank, wcnt=1. No flag is raised and full banks are untouched.
- Read FSM states: IDLE, RD.
  - IDLE -> RD when obank_full[rb]=1.
  - Read address = r*pCOLS + c, with the row index r incrementing fastest. The sequence is column 0 rows 0..pROWS-1, then column 1, and so on.
- Read timing:
  - RAM read latency is 1 cycle.
  - A 2-entry output skid register holds data. tdata/tvalid/tlast are stable while tvalid=1 and tready=0.
  - No RAM read is issued unless the skid has room.
- Latency: first tvalid asserts exactly 2 cycles after obank_full[rb] rises, given tready=1.
- Throughput: with tready=1, one LLR per cycle continuously, including across a bank switch when the next bank is already full (no bubble).
- tlast is asserted on element N-1, i.e. r=pROWS-1, c=pCOLS-1.
- Bank release: when element N-1 is accepted (tvalid&tready), clear obank_full[rb] and toggle rb.
- Same-cycle set and clear of one bank is impossible by construction, because wb != rb whenever both are busy.
- Simultaneous release of bank b and a write-side fill completion targeting bank b: the write side sees the bank as free. No DROP and no ovf.
- rst mid-block discards all stored data and returns every state to its reset values on the next edge.

Optional Feature:
- Macro: LLR_SAT_EN.
- Defined: an input LLR equal to -2^(pLLR_W-1) (-16 for width 5) is clamped to -(2^(pLLR_W-1)-1) (-15) before the write. This keeps the soft range symmetric for the decoder. No added latency.
- Undefined: ibit is stored unmodified.

Decomposition:
- Package rx_deint_pkg holds:
  - typedef llr_t (signed [pLLR_W-1:0]);
  - write FSM enum (WR, DROP) and read FSM enum (IDLE, RD);
  - localparam for N and address width $clog2(N)+1, where the bank bit is the MSB.
- One sub-module, deint_bank_ram: simple dual-port RAM, depth 2N, width pLLR_W, registered read. It contains no control logic.

Test Plan (pROWS=4, pCOLS=8, N=32 unless stated):
1. Basic order. Stimulus: isof on the first sample, 32 LLRs with value k mod 16, tready=1. Response: output sequence 0,8,0,8,1,9,1,9,… (address c + 8r). tlast only on the 32nd word. First tvalid 2 cycles after obank_full[0] rises.
2. Backpressure. Stimulus: same block with tready toggled 1,0,0,1,… Response: the identical 32-value sequence with no loss or duplication. tdata holds during tready=0.
3. Ping-pong continuity. Stimulus: 3 back-to-back blocks, tready=1. Response: 96 outputs, no tvalid gaps after the first, tlast every 32nd word, ovf=0.
4. Overflow. Stimulus: tready=0 while 2 full blocks plus 5 samples are input. Response: ovf=1; the 5 samples are dropped. After tready=1, exactly blocks 1 and 2 are output, then writing resumes.
5. isof resync. Stimulus: isof at wcnt=10 carrying value 7. Response: 7 appears as the first output of that block, ovf unchanged, the previous full bank is output intact.
6. Saturation with LLR_SAT_EN defined. Stimulus: a block with ibit=-16 at k=0. Response: first output = -15. With the macro undefined, first output = -16.

Source files
------------

// File: rtl/rx_deint_pkg.sv
// Shared types and sizing for the soft-bit block deinterleaver.
package rx_deint_pkg;

  localparam int LLR_W  = 5;
  localparam int ROWS   = 32;
  localparam int COLS   = 64;
  localparam int N      = ROWS * COLS;
  localparam int ADDR_W = $clog2(N) + 1;

  typedef logic signed [LLR_W-1:0] llr_t;

  typedef enum logic {WR = 1'b0, DROP = 1'b1} wr_state_t;
  typedef enum logic {IDLE = 1'b0, RD = 1'b1} rd_state_t;

  // Bank-select bit sits above the in-bank linear address.
  function automatic int blk_addr_w(input int rows, input int cols);
    return $clog2(rows * cols) + 1;
  endfunction

endpackage

// File: rtl/deint_bank_ram.sv
// Simple dual-port storage for both ping-pong banks; registered read, no control.
module deint_bank_ram #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/llr_block_deint.sv
// Ping-pong LLR block deinterleaver: row-major write, column-major read, AXI-stream out.
// Build option: define LLR_SAT_EN to clamp the most-negative LLR to the symmetric minimum.
module llr_block_deint
  import rx_deint_pkg::*;
#(
  parameter int pLLR_W = LLR_W,
  parameter int pROWS  = ROWS,
  parameter int pCOLS  = COLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ival,
  input  logic signed [pLLR_W-1:0] ibit,
  input  logic                     isof,
  output logic signed [pLLR_W-1:0] m_ax_tdata,
  output logic                     m_ax_tvalid,
  input  logic                     m_ax_tready,
  output logic                     m_ax_tlast,
  output logic                     ovf,
  output logic [1:0]               obank_full
);

  localparam int NB = pROWS * pCOLS;
  localparam int CW = $clog2(NB);
  localparam int RB = $clog2(pROWS);
  localparam int AW = blk_addr_w(pROWS, pCOLS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  function automatic logic signed [pLLR_W-1:0] sat_llr(input logic signed [pLLR_W-1:0] x);
`ifdef LLR_SAT_EN
    logic signed [pLLR_W-1:0] most_neg;
    most_neg = {1'b1, {(pLLR_W-1){1'b0}}};
    return (x == most_neg) ? (x | {{(pLLR_W-1){1'b0}}, 1'b1}) : x;
`else
    return x;
`endif
  endfunction

  wr_state_t                 wstate;
  rd_state_t                 rstate;
  logic                      wb, rb, ib;
  logic [CW-1:0]             wcnt, icnt, wr_idx;
  logic [1:0]                bank_full, set_mask, clr_mask;
  logic                      wr_en, fill_done, next_busy, rel;
  logic signed [pLLR_W-1:0]  wr_llr;
  logic                      rd_go, room, issue, issue_last, pop;
  logic [1:0]                occ;
  logic [AW-1:0]             rd_addr;
  logic                      rd_vld_p0, rd_last_p0;
  logic signed [pLLR_W-1:0]  rd_data_p0;
  logic                      head_vld_p1, head_last_p1, spare_vld_p1, spare_last_p1;
  logic signed [pLLR_W-1:0]  head_dat_p1, spare_dat_p1;
  logic                      load0, load1, shift;

  always_comb begin
    wr_en     = (wstate == WR) && ival;
    wr_idx    = isof ? '0 : wcnt;
    wr_llr    = sat_llr(ibit);
    fill_done = wr_en && !isof && (wcnt == LAST_IDX);
    pop       = head_vld_p1 && m_ax_tready;
    rel       = pop && head_last_p1;
    // A bank released in the same cycle it is needed counts as free.
    next_busy = bank_full[!wb] && !(rel && (rb == !wb));
    set_mask  = fill_done ? (wb ? 2'b10 : 2'b01) : 2'b00;
    clr_mask  = rel ? (rb ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate    <= WR;
      wb        <= 1'b0;
      wcnt      <= '0;
      ovf       <= 1'b0;
      bank_full <= 2'b00;
      rb        <= 1'b0;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
      if (rel) rb <= !rb;
      case (wstate)
        WR: begin
          if (ival) begin
            if (isof) begin
              wcnt <= CW'(1);
            end else if (wcnt == LAST_IDX) begin
              wcnt <= '0;
              wb   <= !wb;
              if (next_busy) begin
                wstate <= DROP;
                ovf    <= 1'b1;
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (!bank_full[wb]) begin
            wstate <= WR;
            wcnt   <= '0;
          end
        end
        default: wstate <= WR;
      endcase
    end
  end

  // Read issue: occupancy counts skid entries plus the read already in flight.
  always_comb begin
    occ        = {1'b0, head_vld_p1} + {1'b0, spare_vld_p1} + {1'b0, rd_vld_p0};
    room       = (occ < 2'd2) || pop;
    rd_go      = (rstate == RD) || bank_full[ib];
    issue      = rd_go && room;
    issue_last = (icnt == LAST_IDX);
    // Row index is the fast-moving low part of icnt, so swap fields to get r*pCOLS + c.
    rd_addr    = {ib, icnt[RB-1:0], icnt[CW-1:RB]};
    load0      = rd_vld_p0 && (!head_vld_p1 || (pop && !spare_vld_p1));
    shift      = pop && spare_vld_p1;
    load1      = rd_vld_p0 && !load0;
  end

  deint_bank_ram #(
    .DATA_W(pLLR_W),
    .ADDR_W(AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wb, wr_idx}),
    .wdata(wr_llr),
    .re   (issue),
    .raddr(rd_addr),
    .rdata(rd_data_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate        <= IDLE;
      ib            <= 1'b0;
      icnt          <= '0;
      rd_vld_p0     <= 1'b0;
      rd_last_p0    <= 1'b0;
      head_vld_p1   <= 1'b0;
      head_last_p1  <= 1'b0;
      head_dat_p1   <= '0;
      spare_vld_p1  <= 1'b0;
      spare_last_p1 <= 1'b0;
    end else begin
      // p0: RAM read in flight
      rd_vld_p0  <= issue;
      rd_last_p0 <= issue && issue_last;
      if (issue) begin
        if (issue_last) begin
          icnt   <= '0;
          ib     <= !ib;
          rstate <= bank_full[!ib] ? RD : IDLE;
        end else begin
          icnt   <= icnt + 1'b1;
          rstate <= RD;
        end
      end
      // p1: two-entry skid, head drives the stream
      head_vld_p1  <= load0 || shift || (head_vld_p1 && !pop);
      spare_vld_p1 <= load1 || (spare_vld_p1 && !pop);
      if (load0) begin
        head_dat_p1  <= rd_data_p0;
        head_last_p1 <= rd_last_p0;
      end else if (shift) begin
        head_dat_p1  <= spare_dat_p1;
        head_last_p1 <= spare_last_p1;
      end
      if (load1) spare_last_p1 <= rd_last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (load1) spare_dat_p1 <= rd_data_p0;
  end

  assign m_ax_tdata  = head_dat_p1;
  assign m_ax_tvalid = head_vld_p1;
  assign m_ax_tlast  = head_vld_p1 && head_last_p1;
  assign obank_full  = bank_full;

endmodule

// File: tb/tb_llr_block_deint.sv
// Directed bench for llr_block_deint at 4x8 (N=32); honours LLR_SAT_EN for the clamp case.
module tb_llr_block_deint;

  localparam int W  = 5;
  localparam int R  = 4;
  localparam int C  = 8;
  localparam int NB = R * C;

  logic                clk = 1'b0;
  logic                rst, ival, isof, tready;
  logic signed [W-1:0] ibit, tdata;
  logic                tvalid, tlast, ovf;
  logic [1:0]          bfull;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  int blkv [12][NB];
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  llr_block_deint #(
    .pLLR_W(W),
    .pROWS (R),
    .pCOLS (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ival       (ival),
    .ibit       (ibit),
    .isof       (isof),
    .m_ax_tdata (tdata),
    .m_ax_tvalid(tvalid),
    .m_ax_tready(tready),
    .m_ax_tlast (tlast),
    .ovf        (ovf),
    .obank_full (bfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      q_data.push_back(int'(tdata));
      q_last.push_back(int'(tlast));
      q_cyc.push_back(cyc);
    end
  end

  function automatic int sat_model(input int v);
`ifdef LLR_SAT_EN
    return (v == -16) ? -15 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_blk(input int idx, input bit sof, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      ival = 1'b1;
      ibit = W'(blkv[idx][k]);
      isof = sof && (k == 0);
      @(posedge clk); #1;
    end
    ival = 1'b0;
    isof = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (q_data.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_timeout"}, int'(q_data.size() >= n), 1);
  endtask

  // Output j of a block is stored element r*C + c with r = j % R, c = j / R.
  task automatic check_blk(input string tag, input int base, input int idx);
    for (int j = 0; j < NB; j++) begin
      int addr, got_d, got_l;
      addr  = (j % R) * C + j / R;
      got_d = (base + j < q_data.size()) ? q_data[base + j] : -999;
      got_l = (base + j < q_last.size()) ? q_last[base + j] : -999;
      chk($sformatf("%s_data[%0d]", tag, j), got_d, sat_model(blkv[idx][addr]));
      chk($sformatf("%s_last[%0d]", tag, j), got_l, (j == NB - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int base, t, pv, pd, pr, gaps;
    rst = 1'b1; ival = 1'b0; isof = 1'b0; ibit = '0; tready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      blkv[0][k]  = k & 15;
      blkv[1][k]  = (k + 5) & 15;
      blkv[2][k]  = 15 - (k & 15);
      blkv[3][k]  = (k * 3) & 15;
      blkv[4][k]  = (k * 7 + 2) & 15;
      blkv[5][k]  = (k + 9) & 15;
      blkv[6][k]  = 13;
      blkv[7][k]  = (k * 5 + 3) & 15;
      blkv[8][k]  = (k * 11 + 4) & 15;
      blkv[9][k]  = 14;
      blkv[10][k] = (k == 0) ? 7 : ((k + 2) & 15);
      blkv[11][k] = (k == 0) ? -16 : ((k == 8) ? -1 : (k & 15));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_tlast", int'(tlast), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_bank_full", int'(bfull), 0);
    rst = 1'b0;

    // Basic order and first-output latency
    tready = 1'b1;
    base = q_data.size();
    send_blk(0, 1'b1, NB, 0);
    chk("t1_full0", int'(bfull), 1);
    chk("t1_lat0", int'(tvalid), 0);
    @(posedge clk); #1;
    chk("t1_lat1", int'(tvalid), 0);
    @(posedge clk); #1;
    chk("t1_lat2", int'(tvalid), 1);
    chk("t1_first", int'(tdata), 0);
    wait_out("t1", base + NB, 200);
    check_blk("t1", base, 0);
    @(posedge clk); #1;
    chk("t1_released", int'(bfull), 0);

    // Backpressure with tready 1,0,0,1,...
    tready = 1'b0;
    base = q_data.size();
    send_blk(0, 1'b1, NB, 0);
    t = 0;
    while (q_data.size() < base + NB && t < 400) begin
      tready = pat[t % 4];
      pv = int'(tvalid); pd = int'(tdata); pr = int'(tready);
      @(posedge clk); #1;
      if (pv == 1 && pr == 0) begin
        chk("t2_hold_vld", int'(tvalid), 1);
        chk("t2_hold_data", int'(tdata), pd);
      end
      t++;
    end
    tready = 1'b1;
    chk("t2_timeout", int'(q_data.size() >= base + NB), 1);
    check_blk("t2", base, 0);

    // Three blocks; 2-cycle input gap makes each fill completion coincide with a release
    base = q_data.size();
    send_blk(1, 1'b1, NB, 2);
    send_blk(2, 1'b1, NB, 2);
    send_blk(3, 1'b1, NB, 0);
    wait_out("t3", base + 3 * NB, 300);
    check_blk("t3a", base, 1);
    check_blk("t3b", base + NB, 2);
    check_blk("t3c", base + 2 * NB, 3);
    chk("t3_ovf", int'(ovf), 0);

    // Overflow: two full blocks with output stalled, then 5 dropped samples
    tready = 1'b0;
    base = q_data.size();
    send_blk(4, 1'b1, NB, 0);
    send_blk(5, 1'b1, NB, 0);
    send_blk(6, 1'b0, 5, 2);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_both_full", int'(bfull), 3);
    chk("t4_no_accept", q_data.size(), base);
    tready = 1'b1;
    wait_out("t4", base + 2 * NB, 300);
    gaps = 0;
    for (int j = 1; j < 2 * NB && base + j < q_cyc.size(); j++) begin
      if (q_cyc[base + j] != q_cyc[base + j - 1] + 1) gaps++;
    end
    chk("t4_bubbles", gaps, 0);
    check_blk("t4a", base, 4);
    check_blk("t4b", base + NB, 5);
    base = q_data.size();
    send_blk(7, 1'b0, NB, 0);
    wait_out("t4r", base + NB, 200);
    check_blk("t4r", base, 7);
    chk("t4_ovf_sticky", int'(ovf), 1);

    // Mid-block reset, then isof resync at wcnt=10
    send_blk(9, 1'b1, 10, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_ovf", int'(ovf), 0);
    chk("t5_rst_full", int'(bfull), 0);
    chk("t5_rst_tvalid", int'(tvalid), 0);
    chk("t5_rst_tdata", int'(tdata), 0);
    rst = 1'b0;
    base = q_data.size();
    send_blk(8, 1'b0, NB, 0);
    send_blk(9, 1'b1, 10, 0);
    send_blk(10, 1'b1, NB, 0);
    wait_out("t5", base + 2 * NB, 300);
    check_blk("t5p", base, 8);
    check_blk("t5q", base + NB, 10);
    chk("t5_ovf", int'(ovf), 0);

    // Most-negative LLR at element 0
    base = q_data.size();
    send_blk(11, 1'b1, NB, 0);
    wait_out("t6", base + NB, 200);
`ifdef LLR_SAT_EN
    chk("t6_first", (base < q_data.size()) ? q_data[base] : -999, -15);
`else
    chk("t6_first", (base < q_data.size()) ? q_data[base] : -999, -16);
`endif
    check_blk("t6", base, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
